// File: rtl/special_gate_pkg.sv
// Shared constants for the special_gate XOR/XNOR unit.
package special_gate_pkg;

    // Default operand/result width.
    localparam int DEFAULT_WIDTH = 1;

    // Reset value of each result register bit.
    // The top replicates it to the full result width.
    localparam logic RESULT_RST_BIT = 1'b0;

endpackage : special_gate_pkg

// File: rtl/special_gate_mux2_cell.sv
// 1-bit 2:1 multiplexer cell. It is the only logic primitive used to build
// the XOR/XNOR bits.
module mux2_cell (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);

    // y selects d1 when sel is high, otherwise d0.
    assign y = sel ? d1 : d0;

endmodule : mux2_cell

// File: rtl/special_gate.sv
// Registered XOR/XNOR unit.
// Operand b steers one mux per output bit between a and ~a.
// Results appear one cycle after a qualified input.
module special_gate
    import special_gate_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s_xor,
    output logic [WIDTH-1:0] s_xnor,
    input  logic             in_valid,
    output logic             out_valid
);

    localparam logic [WIDTH-1:0] RESULT_RST = {WIDTH{RESULT_RST_BIT}};

    logic [WIDTH-1:0] a_n;
    logic [WIDTH-1:0] xor_comb;
    logic [WIDTH-1:0] xnor_comb;

    // Inverted data leg that is shared by both mux banks.
    assign a_n = ~a;

    // Two mux cells per bit: b selects ~a for XOR and a for XNOR.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux2_cell u_xor (
            .d0  (a[i]),
            .d1  (a_n[i]),
            .sel (b[i]),
            .y   (xor_comb[i])
        );

        mux2_cell u_xnor (
            .d0  (a_n[i]),
            .d1  (a[i]),
            .sel (b[i]),
            .y   (xnor_comb[i])
        );
    end

    // Capture the results only on qualified cycles.
    // Unqualified (possibly X) operands therefore never reach the registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_xor     <= RESULT_RST;
            s_xnor    <= RESULT_RST;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            s_xor     <= xor_comb;
            s_xnor    <= xnor_comb;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule : special_gate

// File: tb/tb_special_gate.sv
// Directed bench for special_gate, with one WIDTH=1 and one WIDTH=8 instance
// sharing clock, reset and in_valid.
module tb_special_gate;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [0:0] a1, b1, x1, n1;
    logic       v1;
    logic [7:0] a8, b8, x8, n8;
    logic       v8;

    int checks = 0;
    int errors = 0;

    special_gate #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a1),
        .b         (b1),
        .s_xor     (x1),
        .s_xnor    (n1),
        .in_valid  (in_valid),
        .out_valid (v1)
    );

    special_gate #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a8),
        .b         (b8),
        .s_xor     (x8),
        .s_xnor    (n8),
        .in_valid  (in_valid),
        .out_valid (v8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1;
        a1 = 1'b1; b1 = 1'b0; a8 = 8'hA5; b8 = 8'h0F;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks += 6;
            if (x1 !== 1'b0) begin errors++; $display("FAIL reset_x1 cyc%0d: got %b want 0", c, x1); end
            if (n1 !== 1'b0) begin errors++; $display("FAIL reset_n1 cyc%0d: got %b want 0", c, n1); end
            if (v1 !== 1'b0) begin errors++; $display("FAIL reset_v1 cyc%0d: got %b want 0", c, v1); end
            if (x8 !== 8'h00) begin errors++; $display("FAIL reset_x8 cyc%0d: got %h want 00", c, x8); end
            if (n8 !== 8'h00) begin errors++; $display("FAIL reset_n8 cyc%0d: got %h want 00", c, n8); end
            if (v8 !== 1'b0) begin errors++; $display("FAIL reset_v8 cyc%0d: got %b want 0", c, v8); end
        end
        rst_n = 1'b1; in_valid = 1'b0;
    endtask

    task automatic test_truth_table();
        logic va[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic vb[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic ex[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic en[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            a1 = va[i]; b1 = vb[i]; in_valid = 1'b1;
            tick();
            checks += 3;
            if (x1 !== ex[i]) begin errors++; $display("FAIL truth_xor vec%0d: got %b want %b", i, x1, ex[i]); end
            if (n1 !== en[i]) begin errors++; $display("FAIL truth_xnor vec%0d: got %b want %b", i, n1, en[i]); end
            if (v1 !== 1'b1) begin errors++; $display("FAIL truth_valid vec%0d: got %b want 1", i, v1); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_hold();
        a1 = 1'b1; b1 = 1'b0; a8 = 8'hA5; b8 = 8'h0F; in_valid = 1'b1;
        tick();
        checks += 6;
        if (x1 !== 1'b1) begin errors++; $display("FAIL hold_load_x1: got %b want 1", x1); end
        if (n1 !== 1'b0) begin errors++; $display("FAIL hold_load_n1: got %b want 0", n1); end
        if (v1 !== 1'b1) begin errors++; $display("FAIL hold_load_v1: got %b want 1", v1); end
        if (x8 !== 8'hAA) begin errors++; $display("FAIL hold_load_x8: got %h want aa", x8); end
        if (n8 !== 8'h55) begin errors++; $display("FAIL hold_load_n8: got %h want 55", n8); end
        if (v8 !== 1'b1) begin errors++; $display("FAIL hold_load_v8: got %b want 1", v8); end
        // Changed operands, and X operands on the wide instance, while unqualified.
        a1 = 1'b1; b1 = 1'b1; a8 = 'x; b8 = 'x; in_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks += 6;
            if (x1 !== 1'b1) begin errors++; $display("FAIL hold_x1 cyc%0d: got %b want 1", c, x1); end
            if (n1 !== 1'b0) begin errors++; $display("FAIL hold_n1 cyc%0d: got %b want 0", c, n1); end
            if (v1 !== 1'b0) begin errors++; $display("FAIL hold_v1 cyc%0d: got %b want 0", c, v1); end
            if (x8 !== 8'hAA) begin errors++; $display("FAIL hold_x8 cyc%0d: got %h want aa", c, x8); end
            if (n8 !== 8'h55) begin errors++; $display("FAIL hold_n8 cyc%0d: got %h want 55", c, n8); end
            if (v8 !== 1'b0) begin errors++; $display("FAIL hold_v8 cyc%0d: got %b want 0", c, v8); end
        end
        a8 = 8'h00; b8 = 8'h00;
    endtask

    task automatic test_back_to_back();
        logic [7:0] ea, eb, exp_x;
        for (int i = 0; i < 300; i++) begin
            case (i)
                0:       begin ea = 8'h00; eb = 8'h00; end
                1:       begin ea = 8'hFF; eb = 8'h00; end
                2:       begin ea = 8'h00; eb = 8'hFF; end
                3:       begin ea = 8'hFF; eb = 8'hFF; end
                default: begin ea = 8'($urandom_range(0, 255)); eb = 8'($urandom_range(0, 255)); end
            endcase
            a8 = ea; b8 = eb; in_valid = 1'b1;
            tick();
            exp_x = ea ^ eb;
            checks += 4;
            if (x8 !== exp_x) begin errors++; $display("FAIL b2b_xor a=%h b=%h: got %h want %h", ea, eb, x8, exp_x); end
            if (n8 !== ~exp_x) begin errors++; $display("FAIL b2b_xnor a=%h b=%h: got %h want %h", ea, eb, n8, ~exp_x); end
            if (v8 !== 1'b1) begin errors++; $display("FAIL b2b_valid a=%h b=%h: got %b want 1", ea, eb, v8); end
            if (n8 !== ~x8) begin errors++; $display("FAIL b2b_invariant: xnor %h xor %h", n8, x8); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midstream();
        in_valid = 1'b1;
        a8 = 8'h3C; b8 = 8'h0F; a1 = 1'b0; b1 = 1'b1;
        tick();
        checks += 3;
        if (x8 !== 8'h33) begin errors++; $display("FAIL mid_pre_x8: got %h want 33", x8); end
        if (v8 !== 1'b1) begin errors++; $display("FAIL mid_pre_v8: got %b want 1", v8); end
        if (x1 !== 1'b1) begin errors++; $display("FAIL mid_pre_x1: got %b want 1", x1); end
        rst_n = 1'b0; a8 = 8'hFF; b8 = 8'h00; a1 = 1'b1; b1 = 1'b0;
        tick();
        checks += 6;
        if (x8 !== 8'h00) begin errors++; $display("FAIL mid_rst_x8: got %h want 00", x8); end
        if (n8 !== 8'h00) begin errors++; $display("FAIL mid_rst_n8: got %h want 00", n8); end
        if (v8 !== 1'b0) begin errors++; $display("FAIL mid_rst_v8: got %b want 0", v8); end
        if (x1 !== 1'b0) begin errors++; $display("FAIL mid_rst_x1: got %b want 0", x1); end
        if (n1 !== 1'b0) begin errors++; $display("FAIL mid_rst_n1: got %b want 0", n1); end
        if (v1 !== 1'b0) begin errors++; $display("FAIL mid_rst_v1: got %b want 0", v1); end
        rst_n = 1'b1; a8 = 8'h12; b8 = 8'h34; a1 = 1'b1; b1 = 1'b1;
        tick();
        checks += 6;
        if (x8 !== 8'h26) begin errors++; $display("FAIL mid_post_x8: got %h want 26", x8); end
        if (n8 !== 8'hD9) begin errors++; $display("FAIL mid_post_n8: got %h want d9", n8); end
        if (v8 !== 1'b1) begin errors++; $display("FAIL mid_post_v8: got %b want 1", v8); end
        if (x1 !== 1'b0) begin errors++; $display("FAIL mid_post_x1: got %b want 0", x1); end
        if (n1 !== 1'b1) begin errors++; $display("FAIL mid_post_n1: got %b want 1", n1); end
        if (v1 !== 1'b1) begin errors++; $display("FAIL mid_post_v1: got %b want 1", v1); end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0;
        a1 = '0; b1 = '0; a8 = '0; b8 = '0;
        test_reset();
        test_truth_table();
        test_hold();
        test_back_to_back();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_special_gate
